cv32e40p_event_log: RTL and testbench
=====================================

# cv32e40p_event_log

Parametrised per-core instruction-event logger; successor to the single-bit illegal-instruction flag. Sits beside the ID stage and observes NUM_EVT decode-qualified event lines (illegal, ecall, ebreak, …). Keeps a saturating counter per event and a DEPTH-entry capture buffer of event-id/PC records, drained through a valid/ready port. Used by simulation monitors and debug readout; synthesisable.

## Interface
- NUM_EVT, 4, number of event channels (1..16); bit 0 is illegal instruction
- CNT_WIDTH, 16, width of each per-event counter (2..32)
- DEPTH, 8, capture buffer entries; power of two, >= 2
- OVERWRITE, 1, 1 = drop oldest on full, 0 = drop newest on full
- clk_i  in  1  core clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- is_decoding_i  in  1  ID stage is decoding a valid instruction this cycle
- evt_i  in  NUM_EVT  raw event lines; counted only when is_decoding_i=1
- pc_id_i  in  32  PC of the instruction in ID
- clear_i  in  1  synchronous clear of counters, buffer and overflow
- rd_valid_o  out  1  buffer non-empty
- rd_ready_i  in  1  consumer accepts head entry
- rd_evt_o  out  $clog2(NUM_EVT) (min 1)  event index of head entry
- rd_pc_o  out  32  PC of head entry
- cnt_o  out  NUM_EVT*CNT_WIDTH  counters, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
- level_o  out  $clog2(DEPTH)+1  current entry count
- overflow_o  out  1  sticky: at least one record lost
- evt_pulse_o  out  1  registered OR of qualified events (one cycle)

## Operation
- qual = evt_i & {NUM_EVT{is_decoding_i}}.
- Counters: each channel with qual[k]=1 increments by 1; saturates at all-ones, never wraps.
- Capture: if qual != 0, one record {lowest set index, pc_id_i} is pushed; other simultaneous bits are counted but not recorded.
- Pop: rd_valid_o & rd_ready_i removes head.
- Full + push, no pop: OVERWRITE=1 → oldest discarded, new written, level stays DEPTH; OVERWRITE=0 → new discarded. Both set overflow_o.
- Full + push + pop same cycle: both proceed, level stays DEPTH, overflow unchanged.
- Empty + push + pop: no pop (rd_valid_o=0), push proceeds, level becomes 1.
- clear_i highest priority: counters 0, buffer empty, overflow_o 0, evt_pulse_o 0; events and pops in that cycle ignored.
- rd_evt_o/rd_pc_o undefined-but-stable (hold last memory content) when rd_valid_o=0; bench must not check them then.

## Timing
- Reset values: cnt_o 0, level_o 0, rd_valid_o 0, overflow_o 0, evt_pulse_o 0; rd_evt_o/rd_pc_o 0 (storage reset).
- Event at edge N → counter, level_o, rd_valid_o, evt_pulse_o updated after edge N (1-cycle latency).
- rd_* are registered-storage outputs driven combinationally from the head pointer; no combinational path from rd_ready_i to rd_valid_o.
- evt_pulse_o high exactly one cycle per qualifying cycle; back-to-back events keep it high.
- Reset asserted mid-operation clears all state immediately, independent of clk_i.

## Structure
- Package cv32e40p_event_log_pkg: event index constants (EVT_ILLEGAL=0, EVT_ECALL=1, EVT_EBREAK=2, EVT_FENCEI=3), typedef evt_rec_t {idx, pc}.
- Sub-module cv32e40p_event_fifo: DEPTH-entry circular buffer with wr/rd pointers ($clog2(DEPTH) bits, natural wrap), level counter, OVERWRITE mode, flush input. Top holds counters, priority encoder, pulse and overflow flag.

## Test plan
- Reset, then is_decoding_i=1, evt_i=4'b0001, pc 0x100 for one cycle → cnt[0]=1, level_o=1, rd_evt_o=0, rd_pc_o=0x100, evt_pulse_o high one cycle.
- evt_i=4'b0110, is_decoding_i=0 → no counts, no record; then is_decoding_i=1 → cnt[1]=cnt[2]=1, single record idx 1.
- DEPTH=8, OVERWRITE=1, 9 pushes pc 0x0..0x20 step 4, rd_ready_i=0 → level 8, overflow_o=1, head pc 0x4; OVERWRITE=0 → head pc 0x0, tail 0x1C.
- Full buffer, push and pop same cycle → level stays 8, overflow_o stays 0, head advances by one.
- CNT_WIDTH=4, 20 consecutive illegal events → cnt[0]=15, holds at 15.
- clear_i asserted with concurrent event and rd_ready_i → all counters 0, level 0, overflow 0; async rst_ni pulse mid-drain → all outputs at reset values before next edge.

Source files
------------

// File: rtl/cv32e40p_event_log_pkg.sv
// Shared types and helpers for the instruction-event logger.
// Event channel numbering, capture record layout and the priority encoder used at capture.
package cv32e40p_event_log_pkg;

  localparam int unsigned EVT_ILLEGAL = 0;
  localparam int unsigned EVT_ECALL   = 1;
  localparam int unsigned EVT_EBREAK  = 2;
  localparam int unsigned EVT_FENCEI  = 3;

  localparam int unsigned MAX_EVT = 16;
  localparam int unsigned REC_IDX_W = 4;

  typedef struct packed {
    logic [REC_IDX_W-1:0] idx;
    logic [31:0]          pc;
  } evt_rec_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit wins, so the illegal-instruction channel always gets recorded.
  function automatic logic [REC_IDX_W-1:0] lowest_set(input logic [MAX_EVT-1:0] v);
    logic [REC_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_EVT - 1; i >= 0; i--) begin
      if (v[i]) idx = REC_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cv32e40p_event_log_if.sv
// Drain port of the event logger: valid/ready handshake carrying the head capture record.
interface cv32e40p_event_log_if #(
  parameter int unsigned IDX_W = 2
);
  logic             rd_valid_o;
  logic             rd_ready_i;
  logic [IDX_W-1:0] rd_evt_o;
  logic [31:0]      rd_pc_o;

  modport master (
    output rd_valid_o,
    output rd_evt_o,
    output rd_pc_o,
    input  rd_ready_i
  );

  modport slave (
    input  rd_valid_o,
    input  rd_evt_o,
    input  rd_pc_o,
    output rd_ready_i
  );
endinterface

// File: rtl/cv32e40p_event_fifo.sv
// Circular capture buffer with a level counter, flush, and selectable drop-oldest/drop-newest on full.
module cv32e40p_event_fifo
  import cv32e40p_event_log_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned OVERWRITE = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  evt_rec_t                 rec_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output evt_rec_t                 head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     lost_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  evt_rec_t               r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [LVL_W-1:0]       r_level;

  logic                   w_full;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_rd_adv;
  logic [LVL_W-1:0]       w_level_nxt;

  assign w_full   = (r_level == LVL_W'(DEPTH));
  assign valid_o  = (r_level != '0);
  assign w_pop    = pop_i & valid_o;
  // A full buffer in overwrite mode writes over the head slot and drags the read pointer along.
  assign w_wr     = push_i & (~w_full | w_pop | (OVERWRITE != 0));
  assign w_rd_adv = w_pop | (push_i & w_full & (OVERWRITE != 0));
  assign lost_o   = push_i & w_full & ~w_pop;

  assign head_o  = r_mem[r_rd_ptr];
  assign level_o = r_level;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_rd_adv)      w_level_nxt = r_level + LVL_W'(1);
    else if (!w_wr && w_rd_adv) w_level_nxt = r_level - LVL_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
    end
  end

  // NOTE: storage is reset here only because the read port must show zero after reset; flush leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (!flush_i && w_wr) begin
      r_mem[r_wr_ptr] <= rec_i;
    end
  end

endmodule

// File: rtl/cv32e40p_event_log.sv
// Per-core instruction-event logger: saturating per-channel counters, capture buffer of
// {event index, PC} records drained over a valid/ready port, sticky overflow and event pulse.
module cv32e40p_event_log
  import cv32e40p_event_log_pkg::*;
#(
  parameter int unsigned NUM_EVT   = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned OVERWRITE = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           is_decoding_i,
  input  logic [NUM_EVT-1:0]             evt_i,
  input  logic [31:0]                    pc_id_i,
  input  logic                           clear_i,
  cv32e40p_event_log_if.master           rd,
  output logic [NUM_EVT*CNT_WIDTH-1:0]   cnt_o,
  output logic [$clog2(DEPTH):0]         level_o,
  output logic                           overflow_o,
  output logic                           evt_pulse_o
);

  localparam int unsigned IDX_W = idx_width(NUM_EVT);

  logic [NUM_EVT-1:0]   w_qual;
  logic                 w_any;
  evt_rec_t             w_rec;
  evt_rec_t             w_head;
  logic                 w_lost;

  logic [CNT_WIDTH-1:0] r_cnt [NUM_EVT];
  logic                 r_overflow;
  logic                 r_pulse;

  assign w_qual    = evt_i & {NUM_EVT{is_decoding_i}};
  assign w_any     = |w_qual;
  assign w_rec.idx = lowest_set(MAX_EVT'(w_qual));
  assign w_rec.pc  = pc_id_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(NUM_EVT); k++) r_cnt[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < int'(NUM_EVT); k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_EVT); k++) begin
        if (w_qual[k] && (r_cnt[k] != '1)) r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
      r_pulse    <= 1'b0;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_overflow <= r_overflow | w_lost;
      r_pulse    <= w_any;
    end
  end

  cv32e40p_event_fifo #(
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (w_any),
    .rec_i   (w_rec),
    .pop_i   (rd.rd_ready_i),
    .valid_o (rd.rd_valid_o),
    .head_o  (w_head),
    .level_o (level_o),
    .lost_o  (w_lost)
  );

  assign rd.rd_evt_o = IDX_W'(w_head.idx);
  assign rd.rd_pc_o  = w_head.pc;

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_cnt
    assign cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = r_cnt[k];
  end

  assign overflow_o  = r_overflow;
  assign evt_pulse_o = r_pulse;

endmodule

// File: tb/tb_cv32e40p_event_log.sv
// Directed bench: two logger instances (drop-oldest/16-bit counters and drop-newest/4-bit counters)
// share one stimulus stream; a vector table plus hand sequences for full, saturation, clear and reset.
module tb_cv32e40p_event_log;

  logic        clk;
  logic        rst_ni;
  logic        dec;
  logic [3:0]  evt;
  logic [31:0] pc;
  logic        clr;
  logic        rdy;

  logic [63:0] cnt_a;
  logic [3:0]  lvl_a;
  logic        ovf_a;
  logic        pls_a;
  logic [15:0] cnt_b;
  logic [3:0]  lvl_b;
  logic        ovf_b;
  logic        pls_b;

  int checks = 0;
  int errors = 0;

  cv32e40p_event_log_if #(.IDX_W(2)) rd_a ();
  cv32e40p_event_log_if #(.IDX_W(2)) rd_b ();
  assign rd_a.rd_ready_i = rdy;
  assign rd_b.rd_ready_i = rdy;

  cv32e40p_event_log #(.NUM_EVT(4), .CNT_WIDTH(16), .DEPTH(8), .OVERWRITE(1)) u_a (
    .clk_i(clk), .rst_ni(rst_ni), .is_decoding_i(dec), .evt_i(evt), .pc_id_i(pc),
    .clear_i(clr), .rd(rd_a), .cnt_o(cnt_a), .level_o(lvl_a), .overflow_o(ovf_a),
    .evt_pulse_o(pls_a)
  );

  cv32e40p_event_log #(.NUM_EVT(4), .CNT_WIDTH(4), .DEPTH(8), .OVERWRITE(0)) u_b (
    .clk_i(clk), .rst_ni(rst_ni), .is_decoding_i(dec), .evt_i(evt), .pc_id_i(pc),
    .clear_i(clr), .rd(rd_b), .cnt_o(cnt_b), .level_o(lvl_b), .overflow_o(ovf_b),
    .evt_pulse_o(pls_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dec;
    logic [3:0]  evt;
    logic [31:0] pc;
    logic        clr;
    logic        rdy;
    logic [63:0] e_cnt;
    logic [3:0]  e_lvl;
    logic        e_vld;
    logic        e_pls;
    logic        e_ovf;
    logic [1:0]  e_idx;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic [3:0] e, input logic [31:0] p,
                       input logic c, input logic r);
    dec = d; evt = e; pc = p; clr = c; rdy = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'b0001, 32'h100, 1'b0, 1'b0, 64'h0000_0000_0000_0001, 4'd1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h100};
    tbl[1] = '{1'b0, 4'b0110, 32'h104, 1'b0, 1'b0, 64'h0000_0000_0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h100};
    tbl[2] = '{1'b1, 4'b0110, 32'h108, 1'b0, 1'b0, 64'h0000_0001_0001_0001, 4'd2, 1'b1, 1'b1, 1'b0, 2'd0, 32'h100};
    tbl[3] = '{1'b1, 4'b0000, 32'h10C, 1'b0, 1'b1, 64'h0000_0001_0001_0001, 4'd1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h108};
    tbl[4] = '{1'b1, 4'b1000, 32'h110, 1'b0, 1'b1, 64'h0001_0001_0001_0001, 4'd1, 1'b1, 1'b1, 1'b0, 2'd3, 32'h110};
    tbl[5] = '{1'b1, 4'b1001, 32'h114, 1'b0, 1'b0, 64'h0002_0001_0001_0002, 4'd2, 1'b1, 1'b1, 1'b0, 2'd3, 32'h110};
    tbl[6] = '{1'b1, 4'b1111, 32'h118, 1'b1, 1'b1, 64'h0,                   4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};
    tbl[7] = '{1'b0, 4'b0000, 32'h11C, 1'b0, 1'b1, 64'h0,                   4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};
    tbl[8] = '{1'b1, 4'b0100, 32'h200, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 4'd1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h200};

    rst_ni = 1'b0;
    drive(1'b0, 4'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;

    check("rst_cnt_a", cnt_a, 64'h0);
    check("rst_lvl_a", lvl_a, 4'd0);
    check("rst_vld_a", rd_a.rd_valid_o, 1'b0);
    check("rst_ovf_a", ovf_a, 1'b0);
    check("rst_pls_a", pls_a, 1'b0);
    check("rst_evt_a", rd_a.rd_evt_o, 2'd0);
    check("rst_pc_a", rd_a.rd_pc_o, 32'h0);
    check("rst_cnt_b", cnt_b, 16'h0);

    // Table: single event, gating, multi-bit capture, pops, clear priority, empty push+pop.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].dec, tbl[i].evt, tbl[i].pc, tbl[i].clr, tbl[i].rdy);
      tick();
      check($sformatf("v%0d_cnt", i), cnt_a, tbl[i].e_cnt);
      check($sformatf("v%0d_lvl", i), lvl_a, tbl[i].e_lvl);
      check($sformatf("v%0d_vld", i), rd_a.rd_valid_o, tbl[i].e_vld);
      check($sformatf("v%0d_pls", i), pls_a, tbl[i].e_pls);
      check($sformatf("v%0d_ovf", i), ovf_a, tbl[i].e_ovf);
      if (tbl[i].e_vld) begin
        check($sformatf("v%0d_idx", i), rd_a.rd_evt_o, tbl[i].e_idx);
        check($sformatf("v%0d_pc", i), rd_a.rd_pc_o, tbl[i].e_pc);
      end
    end

    // Nine pushes into an 8-deep buffer with no consumer.
    drive(1'b0, 4'b0, 32'h0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'b0001, 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    check("ovr_lvl_a", lvl_a, 4'd8);
    check("ovr_ovf_a", ovf_a, 1'b1);
    check("ovr_lvl_b", lvl_b, 4'd8);
    check("ovr_ovf_b", ovf_b, 1'b1);
    check("ovr_cnt_a", cnt_a, 64'h9);
    check("ovr_cnt_b", cnt_b, 16'h9);
    drive(1'b0, 4'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_pc_a", i), rd_a.rd_pc_o, 64'((i + 1) * 4));
      check($sformatf("drain%0d_pc_b", i), rd_b.rd_pc_o, 64'(i * 4));
      tick();
    end
    check("drain_lvl_a", lvl_a, 4'd0);
    check("drain_lvl_b", lvl_b, 4'd0);

    // Full buffer with simultaneous push and pop.
    drive(1'b0, 4'b0, 32'h0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'b0010, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    check("full_lvl_a", lvl_a, 4'd8);
    check("full_ovf_a", ovf_a, 1'b0);
    drive(1'b1, 4'b0100, 32'h400, 1'b0, 1'b1);
    tick();
    check("pp_lvl_a", lvl_a, 4'd8);
    check("pp_ovf_a", ovf_a, 1'b0);
    check("pp_pc_a", rd_a.rd_pc_o, 32'h304);
    check("pp_lvl_b", lvl_b, 4'd8);
    check("pp_ovf_b", ovf_b, 1'b0);
    check("pp_pc_b", rd_b.rd_pc_o, 32'h304);
    drive(1'b0, 4'b0, 32'h0, 1'b0, 1'b1);
    repeat (7) tick();
    check("pp_tail_idx_a", rd_a.rd_evt_o, 2'd2);
    check("pp_tail_pc_a", rd_a.rd_pc_o, 32'h400);
    check("pp_tail_pc_b", rd_b.rd_pc_o, 32'h400);
    check("pp_tail_lvl_b", lvl_b, 4'd1);

    // Counter saturation on the 4-bit instance.
    drive(1'b0, 4'b0, 32'h0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'b0001, 32'h600, 1'b0, 1'b0);
      tick();
      if (i == 14) check("sat15_cnt_b", cnt_b, 16'h000F);
      if (i == 9)  check("pulse_hold_a", pls_a, 1'b1);
    end
    check("sat_cnt_b", cnt_b, 16'h000F);
    check("sat_cnt_a", cnt_a, 64'h14);

    // Asynchronous reset in the middle of a drain.
    drive(1'b1, 4'b0001, 32'h500, 1'b0, 1'b1);
    tick();
    check("pre_rst_pls_a", pls_a, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_cnt_a", cnt_a, 64'h0);
    check("arst_lvl_a", lvl_a, 4'd0);
    check("arst_vld_a", rd_a.rd_valid_o, 1'b0);
    check("arst_ovf_a", ovf_a, 1'b0);
    check("arst_pls_a", pls_a, 1'b0);
    check("arst_evt_a", rd_a.rd_evt_o, 2'd0);
    check("arst_pc_a", rd_a.rd_pc_o, 32'h0);
    check("arst_cnt_b", cnt_b, 16'h0);
    check("arst_lvl_b", lvl_b, 4'd0);
    check("arst_ovf_b", ovf_b, 1'b0);
    drive(1'b0, 4'b0, 32'h0, 1'b0, 1'b0);
    #1;
    rst_ni = 1'b1;
    tick();
    check("post_rst_lvl_a", lvl_a, 4'd0);
    check("post_rst_pls_b", pls_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
